aes_key_loader: RTL and testbench

- Upstream feeder for the combinational key-expansion stage.
- Collects a 128/192/256-bit cipher key as a stream of 32-bit words over a valid/ready handshake and assembles it into a byte-ordered key register.
- Holds the key stable with key_valid asserted until the consumer acknowledges it.
- The encoder/decoder routes key_out and key_size_o into key expansion, which settles combinationally while key_valid is high.

---
 rtl/aes_key_loader_if.sv | 43 ++++
 rtl/aes_key_loader.sv | 163 ++++++++++++++++
 tb/tb_aes_key_loader.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_loader_if
//  Description : Word-stream and key-delivery signal bundle for the AES key
//                loader. The master side feeds key words and acknowledges the
//                assembled key; the slave side is the loader itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_key_loader_if #(
    parameter int WORD_BITS     = 32,
    parameter int MAX_KEY_BYTES = 32
);
    logic                         word_valid;
    logic [WORD_BITS-1:0]         word_data;
    logic                         word_ready;
    logic [MAX_KEY_BYTES*8-1:0]   key_out;
    logic [1:0]                   key_size_o;
    logic                         key_valid;
    logic                         key_accept;

    // Key source and key consumer side
    modport master (
        output word_valid,
        output word_data,
        output key_accept,
        input  word_ready,
        input  key_out,
        input  key_size_o,
        input  key_valid
    );

    // Loader side
    modport slave (
        input  word_valid,
        input  word_data,
        input  key_accept,
        output word_ready,
        output key_out,
        output key_size_o,
        output key_valid
    );
endinterface
`default_nettype wire

// File: rtl/aes_key_loader.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_loader
//  Description : Collects a 128/192/256-bit AES cipher key as a stream of
//                32-bit words and presents it, byte 0 in the MSBs, to the
//                combinational key-expansion stage until acknowledged.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_key_loader #(
    parameter int WORD_BITS     = 32,
    parameter int MAX_KEY_BYTES = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [1:0]           key_size_i,
    input  logic                 flush,
    output logic                 busy,
    output logic                 cfg_err,
    aes_key_loader_if.slave      bus
);

    localparam int KEY_BITS  = MAX_KEY_BYTES * 8;
    localparam int NUM_WORDS = KEY_BITS / WORD_BITS;

    localparam logic [1:0] C_SIZE_128 = 2'b00;
    localparam logic [1:0] C_SIZE_192 = 2'b01;
    localparam logic [1:0] C_SIZE_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                 r_state;
    logic [2:0]             r_count;
    logic [2:0]             r_last;
    logic [KEY_BITS-1:0]    r_key;
    logic [1:0]             r_size;
    logic                   r_word_ready;
    logic                   r_key_valid;
    logic                   r_busy;
    logic                   r_cfg_err;

    logic                   w_hs;
    logic [NUM_WORDS-1:0]   w_word_sel;
    logic [KEY_BITS-1:0]    w_key_next;
    logic [2:0]             w_last_for_size;

    // word_ready is a registered state decode, so the handshake has no
    // combinational dependence on word_valid feeding back to the source.
    assign w_hs = bus.word_valid & r_word_ready;

    // One-hot select of the key word slot addressed by the current count
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
            assign w_word_sel[gi] = (r_count == 3'(gi));
        end
    endgenerate

    // Key register with the incoming word merged into its slot; word 0 lands
    // in the most significant bits so key byte 0 sits at the top.
    always_comb begin
        w_key_next = r_key;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (w_word_sel[i]) begin
                w_key_next[KEY_BITS-1-i*WORD_BITS -: WORD_BITS] = bus.word_data;
            end
        end
    end

    // Index of the final word for the requested key size (NW-1)
    always_comb begin
        w_last_for_size = 3'd7;
        if (key_size_i == C_SIZE_128) begin
            w_last_for_size = 3'd3;
        end else if (key_size_i == C_SIZE_192) begin
            w_last_for_size = 3'd5;
        end
    end

    // Load sequencer: IDLE -> LOAD (collect NW words) -> HOLD (await accept)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_count      <= 3'd0;
            r_last       <= 3'd0;
            r_key        <= '0;
            r_size       <= 2'b00;
            r_word_ready <= 1'b0;
            r_key_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            if (flush) begin
                // Abort wins over everything; the last key contents are kept.
                r_state      <= ST_IDLE;
                r_count      <= 3'd0;
                r_word_ready <= 1'b0;
                r_key_valid  <= 1'b0;
                r_busy       <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            if (key_size_i == C_SIZE_RSV) begin
                                r_cfg_err <= 1'b1;
                            end else begin
                                r_state      <= ST_LOAD;
                                r_size       <= key_size_i;
                                r_last       <= w_last_for_size;
                                r_key        <= '0;
                                r_count      <= 3'd0;
                                r_word_ready <= 1'b1;
                                r_busy       <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (w_hs) begin
                            r_key <= w_key_next;
                            if (r_count == r_last) begin
                                // Count stops here, so it never wraps.
                                r_state      <= ST_HOLD;
                                r_word_ready <= 1'b0;
                                r_key_valid  <= 1'b1;
                            end else begin
                                r_count <= r_count + 3'd1;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (bus.key_accept) begin
                            r_state     <= ST_IDLE;
                            r_count     <= 3'd0;
                            r_key_valid <= 1'b0;
                            r_busy      <= 1'b0;
                        end
                    end
                    default: begin
                        r_state      <= ST_IDLE;
                        r_count      <= 3'd0;
                        r_word_ready <= 1'b0;
                        r_key_valid  <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.word_ready = r_word_ready;
    assign bus.key_out    = r_key;
    assign bus.key_size_o = r_size;
    assign bus.key_valid  = r_key_valid;
    assign busy           = r_busy;
    assign cfg_err        = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_key_loader
//  Description : Directed self-checking bench for aes_key_loader using
//                known AES key vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_loader;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [1:0] key_size_i;
    logic       flush;
    logic       busy;
    logic       cfg_err;

    int n_checks;
    int n_errors;
    int hs_count;
    int kv_count;

    aes_key_loader_if bus ();

    aes_key_loader dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .key_size_i (key_size_i),
        .flush      (flush),
        .busy       (busy),
        .cfg_err    (cfg_err),
        .bus        (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Handshake and key_valid cycle counters
    always @(posedge clock) begin
        if (bus.word_valid && bus.word_ready && !flush) hs_count <= hs_count + 1;
        if (bus.key_valid) kv_count <= kv_count + 1;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [1:0] sz);
        start      = 1'b1;
        key_size_i = sz;
        tick();
        start      = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d);
        int waited;
        waited = 0;
        bus.word_valid = 1'b1;
        bus.word_data  = d;
        while (!bus.word_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!bus.word_ready) check("word_ready_timeout", 256'd0, 256'd1);
        tick();
        bus.word_valid = 1'b0;
    endtask

    task automatic accept_key();
        bus.key_accept = 1'b1;
        tick();
        bus.key_accept = 1'b0;
    endtask

    logic [31:0] w128 [4];
    logic [31:0] w256 [8];
    logic [31:0] w192 [6];
    int          hs_base;
    int          kv_base;

    initial begin
        n_checks = 0; n_errors = 0; hs_count = 0; kv_count = 0;
        reset_n = 1'b0; start = 1'b0; key_size_i = 2'b00; flush = 1'b0;
        bus.word_valid = 1'b0; bus.word_data = 32'd0; bus.key_accept = 1'b0;
        w128 = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
        w256 = '{32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
                 32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4};
        w192 = '{32'h8e73b0f7, 32'hda0e6452, 32'hc810f32b, 32'h809079e5,
                 32'h62f8ead2, 32'h522c6b7b};
        repeat (3) tick();

        // Reset state
        check("rst_key_out",    bus.key_out, 256'd0);
        check("rst_key_size",   256'(bus.key_size_o), 256'd0);
        check("rst_key_valid",  256'(bus.key_valid), 256'd0);
        check("rst_word_ready", 256'(bus.word_ready), 256'd0);
        check("rst_busy",       256'(busy), 256'd0);
        check("rst_cfg_err",    256'(cfg_err), 256'd0);
        reset_n = 1'b1;
        tick();
        check("idle_word_ready", 256'(bus.word_ready), 256'd0);

        // 128-bit load, back-to-back words
        hs_base = hs_count;
        do_start(2'b00);
        check("l128_word_ready", 256'(bus.word_ready), 256'd1);
        check("l128_busy",       256'(busy), 256'd1);
        for (int i = 0; i < 3; i++) send_word(w128[i]);
        check("l128_kv_early",   256'(bus.key_valid), 256'd0);
        send_word(w128[3]);
        check("l128_kv_rise",    256'(bus.key_valid), 256'd1);
        check("l128_key",        bus.key_out,
              {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'd0});
        check("l128_size",       256'(bus.key_size_o), 256'd0);
        check("l128_hold_ready", 256'(bus.word_ready), 256'd0);
        check("l128_hs",         256'(hs_count - hs_base), 256'd4);
        accept_key();
        check("l128_acc_kv",     256'(bus.key_valid), 256'd0);

        // 256-bit load with a two-cycle stall between words 3 and 4
        hs_base = hs_count;
        do_start(2'b10);
        for (int i = 0; i < 3; i++) send_word(w256[i]);
        tick(); tick();
        check("l256_stall_ready", 256'(bus.word_ready), 256'd1);
        for (int i = 3; i < 8; i++) send_word(w256[i]);
        check("l256_kv",   256'(bus.key_valid), 256'd1);
        check("l256_key",  bus.key_out,
              256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
        check("l256_size", 256'(bus.key_size_o), 256'd2);
        check("l256_hs",   256'(hs_count - hs_base), 256'd8);
        // start during HOLD, together with accept, must be ignored
        start = 1'b1; key_size_i = 2'b00; bus.key_accept = 1'b1;
        tick();
        start = 1'b0; bus.key_accept = 1'b0;
        check("l256_acc_busy",  256'(busy), 256'd0);
        check("l256_acc_ready", 256'(bus.word_ready), 256'd0);
        check("l256_key_kept",  bus.key_out,
              256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);

        // 192-bit load, consumer delays acknowledge
        do_start(2'b01);
        for (int i = 0; i < 6; i++) send_word(w192[i]);
        check("l192_key",  bus.key_out,
              {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'd0});
        check("l192_size", 256'(bus.key_size_o), 256'd1);
        repeat (5) tick();
        check("l192_kv_held", 256'(bus.key_valid), 256'd1);
        check("l192_busy_held", 256'(busy), 256'd1);
        accept_key();
        check("l192_acc_kv",   256'(bus.key_valid), 256'd0);
        check("l192_acc_busy", 256'(busy), 256'd0);

        // Reserved key size
        do_start(2'b11);
        check("rsv_cfg_err", 256'(cfg_err), 256'd1);
        check("rsv_busy",    256'(busy), 256'd0);
        check("rsv_ready",   256'(bus.word_ready), 256'd0);
        tick();
        check("rsv_cfg_err_end", 256'(cfg_err), 256'd0);
        check("rsv_ready_2",     256'(bus.word_ready), 256'd0);

        // Flush after two words, then a fresh 128-bit load
        kv_base = kv_count;
        do_start(2'b00);
        send_word(w128[0]);
        send_word(w128[1]);
        flush = 1'b1;
        bus.word_valid = 1'b1; bus.word_data = 32'hdeadbeef;
        tick();
        flush = 1'b0; bus.word_valid = 1'b0;
        check("fl_busy",  256'(busy), 256'd0);
        check("fl_ready", 256'(bus.word_ready), 256'd0);
        check("fl_key_kept", bus.key_out, {64'h2b7e151628aed2a6, 192'd0});
        repeat (2) tick();
        check("fl_kv_never", 256'(kv_count - kv_base), 256'd0);
        do_start(2'b00);
        send_word(32'h00010203);
        send_word(32'h04050607);
        send_word(32'h08090a0b);
        send_word(32'h0c0d0e0f);
        check("fl_reload_kv",  256'(bus.key_valid), 256'd1);
        check("fl_reload_key", bus.key_out,
              {128'h000102030405060708090a0b0c0d0e0f, 128'd0});

        // Asynchronous reset while holding a key
        reset_n = 1'b0;
        #1;
        check("arst_kv",   256'(bus.key_valid), 256'd0);
        check("arst_busy", 256'(busy), 256'd0);
        check("arst_key",  bus.key_out, 256'd0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
